key_event_unit: RTL and testbench

// N-channel successor to the single-key debouncer: synchronises, debounces and classifies
// the board push-buttons in one block. Each channel gives a level plus one-cycle press,

---
 rtl/key_event_pkg.sv | 18 +
 rtl/key_channel.sv | 135 +++++++++++++
 rtl/key_event_unit.sv | 56 +++++
 tb/tb_key_event_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// Shared types and default timing constants for the key event unit.
package key_event_pkg;

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      HOLD_WAIT   = 2'd1,
      HOLD_REPEAT = 2'd2
   } hold_state_t;

   localparam int unsigned DefNKeys        = 4;
   localparam int unsigned DefCntW         = 24;
   localparam int unsigned DefDebCycles    = 4096;
   localparam int unsigned DefRepeatDelay  = 1500000;
   localparam int unsigned DefRepeatPeriod = 300000;
   localparam int unsigned DefLongCycles   = 3000000;
   localparam logic [3:0]  DefRepeatMask   = 4'b0011;

endpackage

// File: rtl/key_channel.sv
// One key: 2-FF synchroniser, counter debouncer and hold FSM producing
// press/release/repeat/long pulses.
module key_channel
   import key_event_pkg::*;
#(
   parameter bit          ACTIVE_LOW    = 1'b1,
   parameter int unsigned CNT_W         = DefCntW,
   parameter int unsigned DEB_CYCLES    = DefDebCycles,
   parameter int unsigned REPEAT_DELAY  = DefRepeatDelay,
   parameter int unsigned REPEAT_PERIOD = DefRepeatPeriod,
   parameter int unsigned LONG_CYCLES   = DefLongCycles,
   parameter bit          REPEAT_EN     = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic repeat_o,
   output logic long_o
);

   // Pin level while the key is not pressed.
   localparam logic IdleLvl = ACTIVE_LOW;
   localparam logic [CNT_W-1:0] DebLast    = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] DelayLast  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] LongSat    = CNT_W'(LONG_CYCLES);

   logic sync1_q, sync2_q, pressed;
   logic stable_q, stable_d;
   logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
   hold_state_t state_q, state_d;
   logic press_q, press_d, release_q, release_d;
   logic repeat_q, repeat_d, long_q, long_d;

   assign pressed = ACTIVE_LOW ? ~sync2_q : sync2_q;

   always_comb begin
      stable_d   = stable_q;
      deb_cnt_d  = '0;
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      rep_cnt_d  = rep_cnt_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      repeat_d   = 1'b0;
      long_d     = 1'b0;

      if (pressed != stable_q) begin
         if (deb_cnt_q == DebLast) begin
            stable_d  = pressed;
            press_d   = pressed;
            release_d = ~pressed;
         end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
         end
      end

      if (release_d) begin
         state_d    = RELEASED;
         hold_cnt_d = '0;
         rep_cnt_d  = '0;
      end else begin
         unique case (state_q)
            RELEASED: begin
               hold_cnt_d = '0;
               rep_cnt_d  = '0;
               if (press_d) state_d = HOLD_WAIT;
            end
            HOLD_WAIT: begin
               if (REPEAT_EN && (hold_cnt_q == DelayLast)) begin
                  repeat_d  = 1'b1;
                  rep_cnt_d = '0;
                  state_d   = HOLD_REPEAT;
               end
            end
            HOLD_REPEAT: begin
               if (rep_cnt_q == PeriodLast) begin
                  repeat_d  = 1'b1;
                  rep_cnt_d = '0;
               end else begin
                  rep_cnt_d = rep_cnt_q + 1'b1;
               end
            end
            default: state_d = RELEASED;
         endcase

         // Hold timer saturates at LONG_CYCLES so the long pulse fires once per hold.
         if (state_q != RELEASED) begin
            if (hold_cnt_q == LongLast) long_d = 1'b1;
            if (hold_cnt_q != LongSat) hold_cnt_d = hold_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q    <= IdleLvl;
         sync2_q    <= IdleLvl;
         stable_q   <= 1'b0;
         deb_cnt_q  <= '0;
         hold_cnt_q <= '0;
         rep_cnt_q  <= '0;
         state_q    <= RELEASED;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         repeat_q   <= 1'b0;
         long_q     <= 1'b0;
      end else begin
         sync1_q    <= key_i;
         sync2_q    <= sync1_q;
         stable_q   <= stable_d;
         deb_cnt_q  <= deb_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         rep_cnt_q  <= rep_cnt_d;
         state_q    <= state_d;
         press_q    <= press_d;
         release_q  <= release_d;
         repeat_q   <= repeat_d;
         long_q     <= long_d;
      end
   end

   assign level_o   = stable_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign repeat_o  = repeat_q;
   assign long_o    = long_q;

endmodule

// File: rtl/key_event_unit.sv
// N-channel key synchroniser/debouncer/classifier; one key_channel per pin.
module key_event_unit
   import key_event_pkg::*;
#(
   parameter int unsigned       N_KEYS        = DefNKeys,
   parameter bit                ACTIVE_LOW    = 1'b1,
   parameter int unsigned       CNT_W         = DefCntW,
   parameter int unsigned       DEB_CYCLES    = DefDebCycles,
   parameter int unsigned       REPEAT_DELAY  = DefRepeatDelay,
   parameter int unsigned       REPEAT_PERIOD = DefRepeatPeriod,
   parameter int unsigned       LONG_CYCLES   = DefLongCycles,
   parameter logic [N_KEYS-1:0] REPEAT_MASK   = N_KEYS'(DefRepeatMask)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [N_KEYS-1:0] i_key,
   output logic [N_KEYS-1:0] o_level,
   output logic [N_KEYS-1:0] o_press,
   output logic [N_KEYS-1:0] o_release,
   output logic [N_KEYS-1:0] o_repeat,
   output logic [N_KEYS-1:0] o_long,
   output logic [N_KEYS-1:0] o_event,
   output logic              o_any_held
);

   if (DEB_CYCLES < 2 || REPEAT_PERIOD < 2 || REPEAT_DELAY < 2 || LONG_CYCLES < 2 ||
       (DEB_CYCLES >> CNT_W) != 0 || (REPEAT_PERIOD >> CNT_W) != 0 ||
       (REPEAT_DELAY >> CNT_W) != 0 || (LONG_CYCLES >> CNT_W) != 0) begin : g_bad_params
      $error("key_event_unit: cycle parameters must be >= 2 and < 2**CNT_W");
   end

   for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
      key_channel #(
         .ACTIVE_LOW    (ACTIVE_LOW),
         .CNT_W         (CNT_W),
         .DEB_CYCLES    (DEB_CYCLES),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD),
         .LONG_CYCLES   (LONG_CYCLES),
         .REPEAT_EN     (REPEAT_MASK[i])
      ) u_ch (
         .clk_i     (i_clk),
         .rst_ni    (i_rst_n),
         .key_i     (i_key[i]),
         .level_o   (o_level[i]),
         .press_o   (o_press[i]),
         .release_o (o_release[i]),
         .repeat_o  (o_repeat[i]),
         .long_o    (o_long[i])
      );
   end

   assign o_event    = o_press | o_repeat;
   assign o_any_held = |o_level;

endmodule

// File: tb/tb_key_event_unit.sv
// Bench for key_event_unit: windowed debounce / elapsed-hold model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_key_event_unit;

   localparam int unsigned NK   = 4;
   localparam int unsigned DEB  = 4;
   localparam int unsigned RD   = 20;
   localparam int unsigned RP   = 5;
   localparam int unsigned LONG = 40;
   localparam logic [NK-1:0] MASK = 4'b0011;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NK-1:0] key = '1;
   logic [NK-1:0] level, press, rel, rep, lng, evt;
   logic          any_held;

   key_event_unit #(
      .N_KEYS        (NK),
      .ACTIVE_LOW    (1'b1),
      .CNT_W         (24),
      .DEB_CYCLES    (DEB),
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP),
      .LONG_CYCLES   (LONG),
      .REPEAT_MASK   (MASK)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_key      (key),
      .o_level    (level),
      .o_press    (press),
      .o_release  (rel),
      .o_repeat   (rep),
      .o_long     (lng),
      .o_event    (evt),
      .o_any_held (any_held)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Model state: per-channel history of pressed samples, one per clock edge.
   bit            hist[NK][$];
   bit            m_stable[NK];
   bit            m_held[NK];
   int            m_el[NK];
   logic [NK-1:0] e_level, e_press, e_rel, e_rep, e_long;

   // Observed pulse counters (DUT) and model repeat counter.
   int d_press[NK], d_rel[NK], d_rep[NK], d_long[NK], d_evt[NK], m_rep[NK];
   int press_cyc[NK], first_rep[NK];

   function automatic bit hget(int c, int idx);
      if (idx < 0) return 1'b0;
      return hist[c][idx];
   endfunction

   task automatic model_step();
      e_press = '0; e_rel = '0; e_rep = '0; e_long = '0;
      for (int c = 0; c < NK; c++) begin
         if (!rst_n) begin
            hist[c].delete();
            m_stable[c] = 1'b0;
            m_held[c]   = 1'b0;
            m_el[c]     = 0;
         end else begin
            int  n;
            bit  flip;
            hist[c].push_back(~key[c]);
            n = hist[c].size();
            // Flip once the last DEB synchronised samples (2 edges old) all disagree.
            flip = 1'b1;
            for (int j = n - 2 - int'(DEB); j <= n - 3; j++)
               if (hget(c, j) == m_stable[c]) flip = 1'b0;
            if (flip) begin
               m_stable[c] = ~m_stable[c];
               if (m_stable[c]) begin
                  e_press[c] = 1'b1; m_held[c] = 1'b1; m_el[c] = 0;
               end else begin
                  e_rel[c] = 1'b1; m_held[c] = 1'b0;
               end
            end else if (m_held[c]) begin
               m_el[c]++;
               e_rep[c]  = MASK[c] && m_el[c] >= int'(RD) && (m_el[c] - int'(RD)) % int'(RP) == 0;
               e_long[c] = (m_el[c] == int'(LONG));
            end
         end
         e_level[c] = m_stable[c];
      end
   endtask

   initial begin
      for (int c = 0; c < NK; c++) begin
         d_press[c] = 0; d_rel[c] = 0; d_rep[c] = 0; d_long[c] = 0; d_evt[c] = 0;
         m_rep[c] = 0; press_cyc[c] = -1; first_rep[c] = -1;
      end
   end

   always @(posedge clk) begin
      cyc++;
      model_step();
      #1;
      chk("level", level, e_level);
      chk("press", press, e_press);
      chk("release", rel, e_rel);
      chk("repeat", rep, e_rep);
      chk("long", lng, e_long);
      chk("event", evt, e_press | e_rep);
      chk("any_held", any_held, |e_level);
      for (int c = 0; c < NK; c++) begin
         if (press[c]) begin
            d_press[c]++; press_cyc[c] = cyc; first_rep[c] = -1;
         end
         if (rep[c]) begin
            d_rep[c]++;
            if (first_rep[c] < 0) first_rep[c] = cyc;
         end
         if (rel[c]) d_rel[c]++;
         if (lng[c]) d_long[c]++;
         if (evt[c]) d_evt[c]++;
         if (e_rep[c]) m_rep[c]++;
      end
   end

   int b_press[NK], b_rel[NK], b_rep[NK], b_long[NK], b_evt[NK], b_mrep[NK];

   task automatic snap();
      for (int c = 0; c < NK; c++) begin
         b_press[c] = d_press[c]; b_rel[c] = d_rel[c]; b_rep[c] = d_rep[c];
         b_long[c] = d_long[c]; b_evt[c] = d_evt[c]; b_mrep[c] = m_rep[c];
      end
   endtask

   initial begin
      int t0;
      repeat (3) @(negedge clk);
      chk("rst_level", level, 4'h0);
      chk("rst_pulses", press | rel | rep | lng, 4'h0);
      chk("rst_any_held", any_held, 1'b0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Single press on key 0: first low sample is edge 1 of the 6-edge latency.
      snap();
      key[0] = 1'b0; t0 = cyc + 1;
      repeat (10) @(negedge clk);
      chk("t1_level", level, 4'b0001);
      chk("t1_press_cnt", d_press[0] - b_press[0], 1);
      chk("t1_press_lat", press_cyc[0] - t0, 5);
      key[0] = 1'b1;
      repeat (10) @(negedge clk);
      chk("t1_others", (d_press[1] - b_press[1]) + (d_press[2] - b_press[2]) +
          (d_press[3] - b_press[3]), 0);
      chk("t1_release_cnt", d_rel[0] - b_rel[0], 1);

      // Glitchy key 1: never four consecutive low samples.
      snap();
      key[1] = 1'b0; repeat (3) @(negedge clk);
      key[1] = 1'b1; repeat (1) @(negedge clk);
      key[1] = 1'b0; repeat (3) @(negedge clk);
      key[1] = 1'b1; repeat (10) @(negedge clk);
      chk("t2_no_press", d_press[1] - b_press[1], 0);
      chk("t2_level", level[1], 1'b0);

      // Long hold on key 0: repeats at 20,25,..,55 after press, long at 40.
      snap();
      key[0] = 1'b0;
      repeat (60) @(negedge clk);
      key[0] = 1'b1;
      repeat (15) @(negedge clk);
      chk("t3_rep_cnt", d_rep[0] - b_rep[0], 8);
      chk("t3_model_rep_cnt", m_rep[0] - b_mrep[0], 8);
      chk("t3_first_rep", first_rep[0] - press_cyc[0], 20);
      chk("t3_long_cnt", d_long[0] - b_long[0], 1);
      chk("t3_event_cnt", d_evt[0] - b_evt[0], 9);
      chk("t3_release_cnt", d_rel[0] - b_rel[0], 1);

      // Long hold on key 2 (repeat disabled).
      snap();
      key[2] = 1'b0;
      repeat (60) @(negedge clk);
      key[2] = 1'b1;
      repeat (15) @(negedge clk);
      chk("t4_press_cnt", d_press[2] - b_press[2], 1);
      chk("t4_long_cnt", d_long[2] - b_long[2], 1);
      chk("t4_rep_cnt", d_rep[2] - b_rep[2], 0);

      // All keys together.
      key = 4'h0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #2;
         if (press != 4'h0) break;
      end
      chk("t5_all_press", press, 4'hF);
      chk("t5_any_held", any_held, 1'b1);
      @(negedge clk);
      key = 4'hF;
      repeat (15) @(negedge clk);

      // Reset in the middle of a repeating hold on key 0.
      snap();
      key[0] = 1'b0;
      repeat (28) @(negedge clk);
      chk("t6_rep_before_rst", d_rep[0] - b_rep[0], 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t6_rst_outputs", level | press | rep | lng | evt, 4'h0);
      @(negedge clk);
      rst_n = 1'b1; t0 = cyc + 1;
      repeat (10) @(negedge clk);
      chk("t6_fresh_press_lat", press_cyc[0] - t0, 5);
      chk("t6_level", level, 4'b0001);
      key[0] = 1'b1;
      repeat (15) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
